sy_tohost_monitor: RTL and testbench

- Synthesizable snoop stage directly downstream of the LSU store path in the simulation SoC.
- Watches committed stores for the riscv-tests tohost address. Keeps a byte-merged shadow of the tohost word and decodes pass, fail or syscall.
- Provides a saturating cycle counter and a timeout, so benches and FPGA builds get a single registered verdict without hierarchical probes into the LSU.

---
 rtl/sy_tohost_monitor_pkg.sv | 19 +
 rtl/sy_tohost_decode.sv | 28 ++
 rtl/sy_tohost_monitor.sv | 96 +++++++++
 tb/tb_sy_tohost_monitor.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sy_tohost_monitor_pkg.sv
// Shared types for the tohost monitor: FSM states, pass encoding, verdict bundle.
package sy_tohost_monitor_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DONE    = 2'd1,
        TIMEOUT = 2'd2
    } tohost_state_e;

    // riscv-tests write 1 to tohost on success.
    localparam int unsigned TOHOST_PASS_VAL = 1;

    typedef struct packed {
        logic pass;
        logic fail;
        logic syscall;
    } tohost_verdict_t;

endpackage

// File: rtl/sy_tohost_decode.sv
// Combinational byte-merge of a store into the tohost shadow plus verdict
// decode of the merged word. Shared with the FPGA status register.
module sy_tohost_decode
    import sy_tohost_monitor_pkg::*;
#(
    parameter int DWTH = 64
) (
    input  logic [DWTH-1:0]   shadow,
    input  logic [DWTH-1:0]   wdata,
    input  logic [DWTH/8-1:0] be,
    output logic [DWTH-1:0]   merged,
    output tohost_verdict_t   verdict
);

    // Per-lane select: enabled lanes take the store byte, others keep the shadow.
    for (genvar i = 0; i < DWTH/8; i++) begin : g_lane
        assign merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : shadow[8*i +: 8];
    end

    // Decode: 1 = pass, other odd = fail, even non-zero = syscall, 0 = nothing.
    always_comb begin
        verdict         = '0;
        verdict.pass    = (merged == DWTH'(TOHOST_PASS_VAL));
        verdict.fail    = merged[0] & ~verdict.pass;
        verdict.syscall = ~merged[0] & (|merged);
    end

endmodule

// File: rtl/sy_tohost_monitor.sv
// Snoops committed stores for the tohost address, keeps a byte-merged shadow
// and produces a single sticky registered verdict (pass/fail/syscall/timeout).
module sy_tohost_monitor
    import sy_tohost_monitor_pkg::*;
#(
    parameter int          AWTH           = 64,
    parameter int          DWTH           = 64,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AWTH-1:0]   tohost_addr_i,
    input  logic              st_valid_i,
    input  logic [AWTH-1:0]   st_addr_i,
    input  logic [DWTH-1:0]   st_wdata_i,
    input  logic [DWTH/8-1:0] st_be_i,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              syscall_o,
    output logic              timeout_o,
    output logic [DWTH-1:0]   tohost_o,
    output logic [DWTH-2:0]   fail_code_o,
    output logic [31:0]       cycle_cnt_o,
    output logic [15:0]       hit_cnt_o
);

    tohost_state_e   state, state_nxt;
    logic [DWTH-1:0] shadow;
    logic [DWTH-1:0] merged;
    tohost_verdict_t verdict;
    logic            hit, eval_hit, tmo_hit, run;

    sy_tohost_decode #(.DWTH(DWTH)) u_decode (
        .shadow  (shadow),
        .wdata   (st_wdata_i),
        .be      (st_be_i),
        .merged  (merged),
        .verdict (verdict)
    );

    // Full-address compare, so a misaligned store never matches.
    assign run      = (state == RUN);
    assign hit      = st_valid_i && (st_addr_i == tohost_addr_i) && (|st_be_i);
    // Only stores covering byte 0 evaluate; a zero merged word is not a verdict.
    assign eval_hit = hit && st_be_i[0] && (|merged);
    assign tmo_hit  = (TIMEOUT_CYCLES != 32'd0) && (cycle_cnt_o == TIMEOUT_CYCLES - 32'd1);

    assign done_o    = (state == DONE);
    assign timeout_o = (state == TIMEOUT);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= RUN;
        else        state <= state_nxt;
    end

    // Next state: a verdict beats a coincident timeout; both end states are terminal.
    always_comb begin
        state_nxt = state;
        if (run) begin
            if (eval_hit)     state_nxt = DONE;
            else if (tmo_hit) state_nxt = TIMEOUT;
        end
    end

    // Shadow merge, hit counting and verdict capture, all frozen outside RUN.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shadow      <= '0;
            hit_cnt_o   <= '0;
            tohost_o    <= '0;
            fail_code_o <= '0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            syscall_o   <= 1'b0;
        end else if (run && hit) begin
            shadow <= merged;
            if (hit_cnt_o != 16'hFFFF) hit_cnt_o <= hit_cnt_o + 16'd1;
            if (eval_hit) begin
                tohost_o    <= merged;
                fail_code_o <= verdict.fail ? merged[DWTH-1:1] : '0;
                pass_o      <= verdict.pass;
                fail_o      <= verdict.fail;
                syscall_o   <= verdict.syscall;
            end
        end
    end

    // Runtime counter: saturates, keeps running after the verdict.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                       cycle_cnt_o <= '0;
        else if (cycle_cnt_o != '1)       cycle_cnt_o <= cycle_cnt_o + 32'd1;
    end

endmodule

// File: tb/tb_sy_tohost_monitor.sv
// Directed bench for sy_tohost_monitor (TIMEOUT_CYCLES = 100).
module tb_sy_tohost_monitor;

    localparam logic [63:0] TOHOST = 64'h8000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] tohost_addr = TOHOST;
    logic        st_valid = 1'b0;
    logic [63:0] st_addr = '0;
    logic [63:0] st_wdata = '0;
    logic [7:0]  st_be = '0;
    logic        done, pass, fail, syscall, timeout;
    logic [63:0] tohost;
    logic [62:0] fail_code;
    logic [31:0] cycle_cnt;
    logic [15:0] hit_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sy_tohost_monitor #(.AWTH(64), .DWTH(64), .TIMEOUT_CYCLES(32'd100)) dut (
        .clk_i(clk), .rst_i(rst), .tohost_addr_i(tohost_addr),
        .st_valid_i(st_valid), .st_addr_i(st_addr), .st_wdata_i(st_wdata), .st_be_i(st_be),
        .done_o(done), .pass_o(pass), .fail_o(fail), .syscall_o(syscall), .timeout_o(timeout),
        .tohost_o(tohost), .fail_code_o(fail_code), .cycle_cnt_o(cycle_cnt), .hit_cnt_o(hit_cnt)
    );

    task automatic do_reset();
        st_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Present one store for one cycle; outputs are sampled on return.
    task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] b);
        @(negedge clk);
        st_valid = 1'b1; st_addr = a; st_wdata = d; st_be = b;
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    // Advance to the negedge where cycle_cnt equals target (bounded).
    task automatic wait_cnt(input logic [31:0] target);
        int n = 0;
        while (cycle_cnt != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (cycle_cnt !== target) begin fails++; $display("FAIL wait_cnt: got %0d want %0d", cycle_cnt, target); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        tests++; if ({done, pass, fail, syscall, timeout} !== 5'b0) begin fails++; $display("FAIL reset_flags: got %b want 00000", {done, pass, fail, syscall, timeout}); end
        tests++; if (tohost !== 64'h0 || fail_code !== 63'h0) begin fails++; $display("FAIL reset_vals: got %h/%h want 0/0", tohost, fail_code); end
        tests++; if (cycle_cnt !== 32'h0 || hit_cnt !== 16'h0) begin fails++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", cycle_cnt, hit_cnt); end
        do_reset();
        tests++; if (cycle_cnt !== 32'h0) begin fails++; $display("FAIL reset_release_cnt: got %0d want 0", cycle_cnt); end
    endtask

    task automatic test_pass();
        do_reset();
        store(TOHOST, 64'h1, 8'hFF);
        tests++; if ({done, pass, fail, syscall, timeout} !== 5'b11000) begin fails++; $display("FAIL pass_flags: got %b want 11000", {done, pass, fail, syscall, timeout}); end
        tests++; if (tohost !== 64'h1 || hit_cnt !== 16'd1) begin fails++; $display("FAIL pass_vals: got %h/%0d want 1/1", tohost, hit_cnt); end
    endtask

    task automatic test_fail();
        do_reset();
        store(TOHOST, 64'h7, 8'hFF);
        tests++; if ({done, pass, fail, syscall} !== 4'b1010) begin fails++; $display("FAIL fail_flags: got %b want 1010", {done, pass, fail, syscall}); end
        tests++; if (fail_code !== 63'd3) begin fails++; $display("FAIL fail_code: got %h want 3", fail_code); end
    endtask

    task automatic test_split_word();
        do_reset();
        store(TOHOST, 64'h0, 8'hF0);
        tests++; if (done !== 1'b0 || hit_cnt !== 16'd1) begin fails++; $display("FAIL split_first: got done=%b hits=%0d want 0/1", done, hit_cnt); end
        store(TOHOST, 64'h1, 8'h0F);
        tests++; if (pass !== 1'b1 || done !== 1'b1 || hit_cnt !== 16'd2) begin fails++; $display("FAIL split_pass: got pass=%b done=%b hits=%0d want 1/1/2", pass, done, hit_cnt); end
        // High half non-zero, then low half 1: merged word is odd and not 1.
        do_reset();
        store(TOHOST, 64'h0000_0001_0000_0000, 8'hF0);
        store(TOHOST, 64'h0000_0000_0000_0001, 8'h0F);
        tests++; if (fail !== 1'b1 || tohost !== 64'h0000_0001_0000_0001) begin fails++; $display("FAIL merge_fail: got fail=%b tohost=%h want 1/0000000100000001", fail, tohost); end
        tests++; if (fail_code !== 63'h8000_0000) begin fails++; $display("FAIL merge_code: got %h want 80000000", fail_code); end
    endtask

    task automatic test_no_hit();
        do_reset();
        store(64'h8000_2000, 64'h1, 8'hFF);
        store(64'h8000_1004, 64'h1, 8'hFF);
        store(TOHOST, 64'h1, 8'h00);
        tests++; if (done !== 1'b0 || hit_cnt !== 16'd0) begin fails++; $display("FAIL no_hit: got done=%b hits=%0d want 0/0", done, hit_cnt); end
        store(TOHOST, 64'h0, 8'hFF);
        tests++; if (done !== 1'b0 || hit_cnt !== 16'd1) begin fails++; $display("FAIL zero_hit: got done=%b hits=%0d want 0/1", done, hit_cnt); end
    endtask

    task automatic test_syscall();
        do_reset();
        store(TOHOST, 64'h80, 8'hFF);
        tests++; if ({done, pass, fail, syscall} !== 4'b1001) begin fails++; $display("FAIL syscall_flags: got %b want 1001", {done, pass, fail, syscall}); end
        store(TOHOST, 64'h1, 8'hFF);
        tests++; if (tohost !== 64'h80 || pass !== 1'b0 || hit_cnt !== 16'd1) begin fails++; $display("FAIL syscall_freeze: got %h/%b/%0d want 80/0/1", tohost, pass, hit_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        store(64'h8000_2000, 64'h1, 8'hFF);
        wait_cnt(32'd99);
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL tmo_early: got %b want 0", timeout); end
        @(negedge clk);
        tests++; if (timeout !== 1'b1 || cycle_cnt !== 32'd100) begin fails++; $display("FAIL tmo_set: got %b at %0d want 1 at 100", timeout, cycle_cnt); end
        store(TOHOST, 64'h1, 8'hFF);
        tests++; if (done !== 1'b0 || hit_cnt !== 16'd0 || timeout !== 1'b1) begin fails++; $display("FAIL tmo_freeze: got done=%b hits=%0d tmo=%b want 0/0/1", done, hit_cnt, timeout); end
        tests++; if (cycle_cnt !== 32'd102) begin fails++; $display("FAIL tmo_cnt_runs: got %0d want 102", cycle_cnt); end
    endtask

    task automatic test_tmo_race();
        // Evaluating hit in the timeout cycle: the verdict wins.
        do_reset();
        wait_cnt(32'd99);
        st_valid = 1'b1; st_addr = TOHOST; st_wdata = 64'h1; st_be = 8'hFF;
        @(negedge clk);
        st_valid = 1'b0;
        tests++; if ({done, pass, timeout} !== 3'b110) begin fails++; $display("FAIL race_hit: got %b want 110", {done, pass, timeout}); end
        // Zero-valued hit in the timeout cycle: timeout, but the hit is counted.
        do_reset();
        wait_cnt(32'd99);
        st_valid = 1'b1; st_addr = TOHOST; st_wdata = 64'h0; st_be = 8'hFF;
        @(negedge clk);
        st_valid = 1'b0;
        tests++; if ({done, timeout} !== 2'b01 || hit_cnt !== 16'd1) begin fails++; $display("FAIL race_zero: got %b hits=%0d want 01 hits=1", {done, timeout}, hit_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        store(TOHOST, 64'h1, 8'hFF);
        #2;
        rst = 1'b0;
        #1;
        tests++; if ({done, pass, fail, syscall, timeout} !== 5'b0 || tohost !== 64'h0 || hit_cnt !== 16'h0 || cycle_cnt !== 32'h0) begin
            fails++; $display("FAIL async_reset: got flags=%b tohost=%h hits=%0d cnt=%0d want all 0", {done, pass, fail, syscall, timeout}, tohost, hit_cnt, cycle_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        tests++; if (cycle_cnt !== 32'h0) begin fails++; $display("FAIL async_restart_cnt: got %0d want 0", cycle_cnt); end
        store(TOHOST, 64'h1, 8'hFF);
        tests++; if (pass !== 1'b1 || done !== 1'b1 || hit_cnt !== 16'd1) begin fails++; $display("FAIL async_repass: got pass=%b done=%b hits=%0d want 1/1/1", pass, done, hit_cnt); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_split_word();
        test_no_hit();
        test_syscall();
        test_timeout();
        test_tmo_race();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
